// File: rtl/timer_pkg.sv
// Shared definitions for the timer_counter slice: FSM states, register offsets,
// CTRL field positions and MODE encodings.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Only MODE 1 reloads; the unused encodings fall back to one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_csr.sv
// Register decode, write logic and read mux for the timer window.
// With TIMER_STATUS_REG_EN defined, writes to offset 0xC raise status_wr.
module timer_csr
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  input  logic              hw_en_clr,
  input  logic [31:0]       count,
  input  logic [31:0]       status,
  output logic [31:0]       rdata,
  output logic [CTRL_W-1:0] ctrl,
  output logic [31:0]       preset,
  output logic              ctrl_wr,
  output logic              status_wr
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       preset_q, preset_d;

  always_comb begin
    ctrl_wr = we && (addr == OFF_CTRL);
`ifdef TIMER_STATUS_REG_EN
    status_wr = we && (addr == OFF_STATUS);
`else
    status_wr = 1'b0;
`endif
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    // A CPU write to CTRL overrides the one-shot hardware EN clear entirely.
    if (ctrl_wr) begin
      ctrl_d = wdata[CTRL_W-1:0];
    end else if (hw_en_clr) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end
    if (we && (addr == OFF_PRESET)) begin
      preset_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      preset_q <= PRESET_RST;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      OFF_PRESET: rdata = preset_q;
      OFF_COUNT:  rdata = count;
      OFF_STATUS: rdata = status;
      default:    rdata = '0;
    endcase
  end

  assign ctrl   = ctrl_q;
  assign preset = preset_q;

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
// Optional status register at 0xC is enabled by defining TIMER_STATUS_REG_EN.
module timer_counter
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e            state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic              irq_flag_q, irq_flag_d;
  logic              flag_set, flag_hw_clr, hw_en_clr;
  logic [CTRL_W-1:0] ctrl;
  logic [31:0]       preset;
  logic [31:0]       status;
  logic              ctrl_wr, status_wr;
  logic              en, im;
  logic [1:0]        mode;

  assign en   = ctrl[CTRL_EN];
  assign mode = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  assign im   = ctrl[CTRL_IM];

`ifdef TIMER_STATUS_REG_EN
  assign status = {27'b0, irq_flag_q, 2'b00, state_q};
`else
  assign status = '0;
`endif

  timer_csr #(
    .PRESET_RST(PRESET_RST)
  ) u_csr (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .we       (we),
    .wdata    (wdata),
    .hw_en_clr(hw_en_clr),
    .count    (count_q),
    .status   (status),
    .rdata    (rdata),
    .ctrl     (ctrl),
    .preset   (preset),
    .ctrl_wr  (ctrl_wr),
    .status_wr(status_wr)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    flag_set    = 1'b0;
    flag_hw_clr = 1'b0;
    hw_en_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset;
        // A zero preset has nothing to count, so it expires straight from LOAD.
        if (preset == 32'd0) begin
          flag_set = 1'b1;
          state_d  = ST_INT;
        end else begin
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d  = '0;
          flag_set = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        if (is_reload(mode)) begin
          flag_hw_clr = 1'b1;
          state_d     = ST_LOAD;
        end else begin
          hw_en_clr = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Setting the flag wins over any clear arriving in the same cycle.
  always_comb begin
    irq_flag_d = irq_flag_q;
    if (flag_hw_clr || ctrl_wr || status_wr) irq_flag_d = 1'b0;
    if (flag_set) irq_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  assign irq = irq_flag_q & im;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus pushes expected reads, a negedge
// monitor pops and compares them. Honors TIMER_STATUS_REG_EN for 0xC reads.
module tb_timer_counter;

  localparam logic [31:0] PRESET_RST = 32'h0000_00A5;
  localparam logic [1:0]  A_CTRL   = 2'd0;
  localparam logic [1:0]  A_PRESET = 2'd1;
  localparam logic [1:0]  A_COUNT  = 2'd2;
  localparam logic [1:0]  A_STATUS = 2'd3;
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_LOAD   = 2'd1;
  localparam logic [1:0]  S_CNT    = 2'd2;
`ifdef TIMER_STATUS_REG_EN
  localparam bit STATUS_ON = 1'b1;
`else
  localparam bit STATUS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        rd_req;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_rdata_q[$];
  logic        exp_irq_q[$];
  string       exp_name_q[$];
  logic [31:0] mon_rdata;
  logic        mon_irq;
  string       mon_name;

  logic [31:0] os_cnt [6];
  logic [31:0] ar_cnt [13];
  logic        ar_irq [13];
  logic [31:0] p0_cnt [7];
  logic        p0_irq [7];

  timer_counter #(
    .PRESET_RST(PRESET_RST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] statusWord(input logic flag, input logic [1:0] st);
    return STATUS_ON ? {27'b0, flag, 2'b00, st} : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (rd_req) begin
      checks++;
      if (exp_rdata_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL monitor: read presented with empty scoreboard, rdata=%h", rdata);
      end else begin
        mon_rdata = exp_rdata_q.pop_front();
        mon_irq   = exp_irq_q.pop_front();
        mon_name  = exp_name_q.pop_front();
        if (rdata !== mon_rdata || irq !== mon_irq) begin
          failures++;
          $display("[TB] FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                   mon_name, rdata, irq, mon_rdata, mon_irq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic w, input logic [31:0] d);
    addr  = a;
    we    = w;
    wdata = d;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] er, input logic ei);
    exp_rdata_q.push_back(er);
    exp_irq_q.push_back(ei);
    exp_name_q.push_back(nm);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    we     = 1'b0;
  endtask

  task automatic readCheck(input string nm, input logic [1:0] a, input logic [31:0] er,
                           input logic ei);
    applyStimulus(a, 1'b0, 32'h0);
    checkOutput(nm, er, ei);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(a, 1'b1, d);
    tick();
    we = 1'b0;
  endtask

  task automatic compareNow(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got irq=%b, expected irq=%b", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    os_cnt = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    ar_cnt = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0,
               32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3};
    ar_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    p0_cnt = '{32'd3, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    p0_irq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    reset  = 1'b0;
    addr   = 2'd0;
    we     = 1'b0;
    wdata  = 32'h0;
    rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] reset values");
    readCheck("rst_ctrl", A_CTRL, 32'h0, 1'b0);
    readCheck("rst_preset", A_PRESET, PRESET_RST, 1'b0);
    readCheck("rst_count", A_COUNT, 32'h0, 1'b0);
    readCheck("rst_status", A_STATUS, statusWord(1'b0, S_IDLE), 1'b0);

    $display("[TB] one-shot, preset 5");
    writeReg(A_PRESET, 32'd5);
    writeReg(A_CTRL, 32'h9);
    readCheck("os_idle", A_COUNT, 32'd0, 1'b0);
    readCheck("os_load", A_COUNT, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      readCheck($sformatf("os_count_%0d", i), A_COUNT, os_cnt[i], (i == 5));
    end
    readCheck("os_ctrl_en_cleared", A_CTRL, 32'h8, 1'b1);
    readCheck("os_irq_held", A_COUNT, 32'd0, 1'b1);
    readCheck("os_status", A_STATUS, statusWord(1'b1, S_IDLE), 1'b1);
    writeReg(A_CTRL, 32'h8);
    readCheck("os_irq_cleared", A_CTRL, 32'h8, 1'b0);

    $display("[TB] auto-reload, preset 3");
    writeReg(A_PRESET, 32'd3);
    writeReg(A_CTRL, 32'hB);
    for (int i = 0; i < 13; i++) begin
      readCheck($sformatf("ar_cycle_%0d", i), A_COUNT, ar_cnt[i], ar_irq[i]);
    end
    writeReg(A_CTRL, 32'h2);
    readCheck("ar_disable_last_dec", A_COUNT, 32'd1, 1'b0);
    readCheck("ar_disable_hold", A_COUNT, 32'd1, 1'b0);

    $display("[TB] masked interrupt");
    writeReg(A_PRESET, 32'd2);
    writeReg(A_CTRL, 32'h1);
    repeat (3) tick();
    readCheck("mask_count1", A_COUNT, 32'd1, 1'b0);
    readCheck("mask_irq_low", A_COUNT, 32'd0, 1'b0);
    readCheck("mask_status_flag", A_STATUS, statusWord(1'b1, S_IDLE), 1'b0);
    readCheck("mask_ctrl_en_cleared", A_CTRL, 32'h0, 1'b0);
    writeReg(A_STATUS, 32'hFFFF_FFFF);
    readCheck("mask_status_cleared", A_STATUS, statusWord(1'b0, S_IDLE), 1'b0);
    readCheck("status_write_no_side", A_PRESET, 32'd2, 1'b0);

    $display("[TB] early disable and re-enable");
    writeReg(A_PRESET, 32'd6);
    writeReg(A_CTRL, 32'h1);
    repeat (4) tick();
    readCheck("ed_count4", A_COUNT, 32'd4, 1'b0);
    writeReg(A_CTRL, 32'h0);
    readCheck("ed_count2", A_COUNT, 32'd2, 1'b0);
    readCheck("ed_frozen", A_COUNT, 32'd2, 1'b0);
    readCheck("ed_status_idle", A_STATUS, statusWord(1'b0, S_IDLE), 1'b0);
    tick();
    readCheck("ed_frozen_later", A_COUNT, 32'd2, 1'b0);
    writeReg(A_CTRL, 32'h1);
    readCheck("re_idle", A_COUNT, 32'd2, 1'b0);
    readCheck("re_load", A_COUNT, 32'd2, 1'b0);
    readCheck("re_reloaded", A_COUNT, 32'd6, 1'b0);
    readCheck("re_status_cnt", A_STATUS, statusWord(1'b0, S_CNT), 1'b0);
    writeReg(A_CTRL, 32'h0);
    tick();

    $display("[TB] CTRL write against hardware EN clear");
    writeReg(A_PRESET, 32'd2);
    writeReg(A_CTRL, 32'h9);
    repeat (2) tick();
    readCheck("ct_count2", A_COUNT, 32'd2, 1'b0);
    readCheck("ct_count1", A_COUNT, 32'd1, 1'b0);
    applyStimulus(A_CTRL, 1'b1, 32'h3);
    checkOutput("ct_int_state", 32'h9, 1'b1);
    readCheck("ct_cpu_wins", A_CTRL, 32'h3, 1'b0);
    readCheck("ct_status_load", A_STATUS, statusWord(1'b0, S_LOAD), 1'b0);
    readCheck("ct_new_load", A_COUNT, 32'd2, 1'b0);

    $display("[TB] preset and count writes");
    writeReg(A_PRESET, 32'd7);
    readCheck("pw_int", A_COUNT, 32'd0, 1'b0);
    readCheck("pw_load", A_COUNT, 32'd0, 1'b0);
    readCheck("pw_reload7", A_COUNT, 32'd7, 1'b0);
    writeReg(A_COUNT, 32'h55);
    readCheck("cw_ignored", A_COUNT, 32'd5, 1'b0);

    $display("[TB] preset 0 auto-reload");
    writeReg(A_CTRL, 32'h0);
    writeReg(A_PRESET, 32'd0);
    writeReg(A_CTRL, 32'hB);
    for (int i = 0; i < 7; i++) begin
      readCheck($sformatf("p0_cycle_%0d", i), A_COUNT, p0_cnt[i], p0_irq[i]);
    end

    $display("[TB] asynchronous reset with irq high");
    tick();
    compareNow("rst_irq_before", irq, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    compareNow("rst_irq_async_drop", irq, 1'b0);
    tick();
    readCheck("rst2_ctrl", A_CTRL, 32'h0, 1'b0);
    readCheck("rst2_count", A_COUNT, 32'h0, 1'b0);
    readCheck("rst2_preset", A_PRESET, PRESET_RST, 1'b0);
    readCheck("rst2_status", A_STATUS, statusWord(1'b0, S_IDLE), 1'b0);
    reset = 1'b1;
    readCheck("post_rst_count", A_COUNT, 32'h0, 1'b0);
    readCheck("post_rst_ctrl", A_CTRL, 32'h0, 1'b0);

    repeat (2) tick();
    if (exp_rdata_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_rdata_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
